line_event_capture: RTL and testbench
=====================================

// Module: line_event_capture
// PURPOSE
//   Upstream feeder for the 8-line to 3-bit encoder stage.
//   - Synchronises 8 asynchronous event lines and detects rising edges (or levels).
//   - Latches events as sticky pending bits.
//   - Presents exactly one pending line at a time as a registered one-hot vector under a
//     valid/ready handshake. Lowest index wins (D0 highest priority), so the encoder's
//     input is never multi-hot.
// PARAMETERS
//   SYNC_STAGES  2  synchroniser flops per line; legal 2..4
//   EDGE_MODE    1  1 = rising edge sets pending; 0 = high level sets pending every cycle
// PORTS
//   clk           input   1  single clock; all state on rising edge
//   rst_n         input   1  asynchronous, active-low reset
//   line_i        input   8  asynchronous event lines; bit i maps to encoder input Di
//   mask_i        input   8  1 = events on line i are dropped; existing pending bit is kept
//   out_onehot_o  output  8  registered one-hot request to the encoder; all 0 when not valid
//   out_valid_o   output  1  out_onehot_o holds an event
//   out_ready_i   input   1  downstream accepts out_onehot_o this cycle
//   pending_o     output  8  current pending bits, excluding the one in the output slot
//   ovf_o         output  8  sticky: an event hit line i while pending[i] was already set
//   ovf_clr_i     input   1  synchronous clear of all ovf_o bits
// BEHAVIOUR
//   Reset
//   - All sync flops, edge-history flops, pending, ovf, out_onehot_o and out_valid_o go to 0.
//   - Edge history resets to 0, so a line held high across reset release yields exactly
//     one event (EDGE_MODE=1).
//   Synchroniser and event detect
//   - sync[i] is the output of the last stage of the synchroniser chain.
//   - EDGE_MODE=1: ev[i] = sync[i] & ~prev[i] & ~mask_i[i].
//   - EDGE_MODE=0: ev[i] = sync[i] & ~mask_i[i].
//   Pending update, per cycle
//   - pending_nxt = (pending & ~load_clr) | ev.
//   - Set wins over clear: an event on the line being loaded this cycle leaves pending set,
//     which is a new event.
//   - ovf[i] sets when ev[i] & pending[i] & ~load_clr[i].
//   - ovf_clr_i clears all ovf bits; a same-cycle set wins over the clear.
//   Output slot (1-entry register)
//   - slot_free = ~out_valid_o | out_ready_i.
//   - If slot_free and pending != 0: load the lowest set pending bit into out_onehot_o,
//     set out_valid_o, and assert load_clr for that bit.
//   - If slot_free and pending == 0: out_valid_o <= 0 and out_onehot_o <= 0.
//   - While out_valid_o & ~out_ready_i, out_onehot_o and out_valid_o hold stable.
//   - Throughput: one event per cycle with out_ready_i held high. No bubble on back-to-back
//     pending bits.
//   - Only the registered pending vector is loaded; same-cycle ev is not bypassed.
//   Latency and pending_o
//   - out_valid_o rises SYNC_STAGES+1 clk edges after the edge that first samples line_i
//     high, provided the slot is free.
//   - pending_o is the registered pending vector, not including the slot entry.
//   Reset mid-operation
//   - Any in-flight slot entry and all pending events are discarded.
//   - out_valid_o drops immediately (asynchronously).
// TESTING
//   - Reset: hold rst_n=0 with line_i=8'hFF -> out_valid_o=0, out_onehot_o=0, pending_o=0,
//     ovf_o=0 throughout.
//   - Single edge: line_i[5] 0->1, ready=1 -> out_onehot_o=8'h20 valid for 1 cycle
//     SYNC_STAGES+1 edges later; pending_o=0 after.
//   - Simultaneous: line_i 0->8'h91, ready=1 -> slot shows 8'h01, 8'h10, 8'h80 on
//     consecutive cycles, then valid=0.
//   - Backpressure: ready=0 with 8'h04 in slot for 10 cycles -> output stable 8'h04;
//     accept -> next pending bit follows the next cycle.
//   - Overflow/mask: two edges on line 3 while ready=0 -> ovf_o=8'h08; ovf_clr_i pulse -> 0.
//     mask_i[3]=1 edge -> no pending, no ovf.
//   - Reset mid-op: rst_n low while valid=1 with pending=8'h0C -> all 0 immediately; lines
//     still high after release -> one event each (EDGE_MODE=1).

Source files
------------

// File: rtl/line_event_capture_if.sv
// Event-capture handshake bundle: raw event lines and masks in, one-hot request plus
// status out.
interface line_event_capture_if;
   logic [7:0] line_i;
   logic [7:0] mask_i;
   logic [7:0] out_onehot_o;
   logic       out_valid_o;
   logic       out_ready_i;
   logic [7:0] pending_o;
   logic [7:0] ovf_o;
   logic       ovf_clr_i;

   modport master (
      output line_i, mask_i, out_ready_i, ovf_clr_i,
      input  out_onehot_o, out_valid_o, pending_o, ovf_o
   );

   modport slave (
      input  line_i, mask_i, out_ready_i, ovf_clr_i,
      output out_onehot_o, out_valid_o, pending_o, ovf_o
   );
endinterface

// File: rtl/line_event_capture.sv
// Synchronises 8 event lines, latches edges/levels as sticky pending bits and hands them
// out one at a time, lowest index first, as a registered one-hot request.
module line_event_capture #(
   parameter int SYNC_STAGES = 2,
   parameter int EDGE_MODE   = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   line_event_capture_if.slave  bus
);

   logic [SYNC_STAGES-1:0][7:0] sync_q;
   logic [7:0]                  prev_q;
   logic [7:0]                  pending_q, pending_d;
   logic [7:0]                  ovf_q, ovf_d;
   logic [7:0]                  onehot_q, onehot_d;
   logic                        valid_q, valid_d;

   logic [7:0] sync_w;
   logic [7:0] ev;
   logic [7:0] lowest;
   logic [7:0] load_clr;
   logic       slot_free;

   assign sync_w = sync_q[SYNC_STAGES-1];
   assign ev     = (EDGE_MODE != 0) ? (sync_w & ~prev_q & ~bus.mask_i)
                                    : (sync_w & ~bus.mask_i);

   // x & -x isolates the lowest set bit, giving D0 the highest priority.
   assign lowest = pending_q & (~pending_q + 8'd1);

   always_comb begin
      slot_free = ~valid_q | bus.out_ready_i;
      load_clr  = 8'd0;
      onehot_d  = onehot_q;
      valid_d   = valid_q;
      if (slot_free) begin
         load_clr = lowest;
         onehot_d = lowest;
         valid_d  = |pending_q;
      end
      pending_d = (pending_q & ~load_clr) | ev;
      ovf_d     = (bus.ovf_clr_i ? 8'd0 : ovf_q) | (ev & pending_q & ~load_clr);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q    <= '0;
         prev_q    <= 8'd0;
         pending_q <= 8'd0;
         ovf_q     <= 8'd0;
         onehot_q  <= 8'd0;
         valid_q   <= 1'b0;
      end else begin
         if (SYNC_STAGES > 1) begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], bus.line_i};
         end else begin
            sync_q <= bus.line_i;
         end
         prev_q    <= sync_w;
         pending_q <= pending_d;
         ovf_q     <= ovf_d;
         onehot_q  <= onehot_d;
         valid_q   <= valid_d;
      end
   end

   assign bus.out_onehot_o = onehot_q;
   assign bus.out_valid_o  = valid_q;
   assign bus.pending_o    = pending_q;
   assign bus.ovf_o        = ovf_q;

endmodule

// File: tb/tb_line_event_capture.sv
// Bench for line_event_capture: directed scenarios followed by random traffic, all
// compared against a cycle-level behavioural model of the capture rules.
module tb_line_event_capture;
   localparam int S = 2;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   line_event_capture_if bus();

   line_event_capture #(.SYNC_STAGES(S), .EDGE_MODE(1)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int n_chk  = 0;
   int n_fail = 0;

   // smp[0] is the newest sample of line_i; smp[S-1] is the synchronised value and
   // smp[S] the value one cycle before it.
   logic [7:0] smp [0:S];
   logic [7:0] m_pend, m_ovf, m_oh;
   logic       m_valid;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k <= S; k++) smp[k] = 8'd0;
      m_pend  = 8'd0;
      m_ovf   = 8'd0;
      m_oh    = 8'd0;
      m_valid = 1'b0;
   endtask

   task automatic model_step();
      logic [7:0] ev, clr;
      int sel;
      if (!rst_n) begin
         model_reset();
         return;
      end
      ev  = 8'd0;
      clr = 8'd0;
      sel = -1;
      for (int i = 0; i < 8; i++)
         ev[i] = smp[S-1][i] & ~smp[S][i] & ~bus.mask_i[i];
      if (!m_valid || bus.out_ready_i) begin
         for (int i = 7; i >= 0; i--)
            if (m_pend[i]) sel = i;
         if (sel >= 0) clr[sel] = 1'b1;
         m_valid = (sel >= 0);
         m_oh    = clr;
      end
      m_ovf  = (bus.ovf_clr_i ? 8'd0 : m_ovf) | (ev & m_pend & ~clr);
      m_pend = (m_pend & ~clr) | ev;
      for (int k = S; k > 0; k--) smp[k] = smp[k-1];
      smp[0] = bus.line_i;
   endtask

   task automatic compare_all();
      chk("onehot",  bus.out_onehot_o, m_oh);
      chk("valid",   {7'd0, bus.out_valid_o}, {7'd0, m_valid});
      chk("pending", bus.pending_o, m_pend);
      chk("ovf",     bus.ovf_o, m_ovf);
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      @(negedge clk);
      compare_all();
   endtask

   task automatic wait_valid(input string tag, output int n);
      n = 0;
      do begin
         tick();
         n++;
      end while (!bus.out_valid_o && n < 20);
      if (!bus.out_valid_o) chk({tag, "_timeout"}, 8'd0, 8'd1);
   endtask

   int n, cnt;
   logic [7:0] flip;

   initial begin
      bus.line_i      = 8'hFF;
      bus.mask_i      = 8'd0;
      bus.out_ready_i = 1'b1;
      bus.ovf_clr_i   = 1'b0;
      model_reset();

      // Held in reset with all lines high: everything stays zero.
      repeat (5) begin
         @(negedge clk);
         chk("rst_onehot", bus.out_onehot_o, 8'h00);
         chk("rst_valid", {7'd0, bus.out_valid_o}, 8'h00);
         chk("rst_pend", bus.pending_o, 8'h00);
         chk("rst_ovf", bus.ovf_o, 8'h00);
      end

      // Lines high across release: exactly one event per line.
      rst_n = 1'b1;
      cnt = 0;
      repeat (16) begin
         tick();
         if (bus.out_valid_o) cnt++;
      end
      chk("held_high_events", 8'(cnt), 8'd8);
      bus.line_i = 8'h00;
      repeat (4) tick();

      // Single edge latency.
      bus.line_i = 8'h20;
      wait_valid("single", n);
      chk("single_latency", 8'(n), 8'(S + 2));
      chk("single_onehot", bus.out_onehot_o, 8'h20);
      tick();
      chk("single_after_valid", {7'd0, bus.out_valid_o}, 8'h00);
      chk("single_after_pend", bus.pending_o, 8'h00);
      bus.line_i = 8'h00;
      repeat (4) tick();

      // Simultaneous edges drain lowest index first, no bubbles.
      bus.line_i = 8'h91;
      wait_valid("simul", n);
      chk("simul_0", bus.out_onehot_o, 8'h01);
      tick();
      chk("simul_1", bus.out_onehot_o, 8'h10);
      tick();
      chk("simul_2", bus.out_onehot_o, 8'h80);
      tick();
      chk("simul_end", {7'd0, bus.out_valid_o}, 8'h00);
      bus.line_i = 8'h00;
      repeat (4) tick();

      // Backpressure holds the slot stable.
      bus.out_ready_i = 1'b0;
      bus.line_i      = 8'h0C;
      wait_valid("bp", n);
      repeat (10) begin
         tick();
         chk("bp_hold", bus.out_onehot_o, 8'h04);
      end
      chk("bp_pend", bus.pending_o, 8'h08);
      bus.out_ready_i = 1'b1;
      tick();
      chk("bp_next", bus.out_onehot_o, 8'h08);
      bus.line_i = 8'h00;
      repeat (4) tick();

      // Overflow on line 3 while the slot is blocked, then clear.
      bus.out_ready_i = 1'b0;
      bus.line_i      = 8'h01;
      wait_valid("ovf", n);
      bus.line_i = 8'h09; repeat (4) tick();
      bus.line_i = 8'h01; repeat (3) tick();
      bus.line_i = 8'h09; repeat (4) tick();
      chk("ovf_set", bus.ovf_o, 8'h08);
      bus.ovf_clr_i = 1'b1;
      tick();
      bus.ovf_clr_i = 1'b0;
      chk("ovf_clr", bus.ovf_o, 8'h00);
      bus.out_ready_i = 1'b1;
      bus.line_i      = 8'h00;
      repeat (6) tick();

      // Masked edge is dropped entirely.
      bus.mask_i = 8'h08;
      bus.line_i = 8'h08;
      repeat (5) tick();
      chk("mask_pend", bus.pending_o, 8'h00);
      chk("mask_ovf", bus.ovf_o, 8'h00);
      chk("mask_valid", {7'd0, bus.out_valid_o}, 8'h00);
      bus.line_i = 8'h00;
      repeat (3) tick();
      bus.mask_i = 8'h00;

      // Reset in the middle of a blocked transfer.
      bus.out_ready_i = 1'b0;
      bus.line_i      = 8'h0D;
      wait_valid("midrst", n);
      repeat (3) tick();
      chk("midrst_pre_pend", bus.pending_o, 8'h0C);
      rst_n = 1'b0;
      #1;
      chk("midrst_valid", {7'd0, bus.out_valid_o}, 8'h00);
      chk("midrst_onehot", bus.out_onehot_o, 8'h00);
      chk("midrst_pend", bus.pending_o, 8'h00);
      model_reset();
      tick();
      rst_n           = 1'b1;
      bus.out_ready_i = 1'b1;
      cnt = 0;
      repeat (12) begin
         tick();
         if (bus.out_valid_o) cnt++;
      end
      chk("midrst_events", 8'(cnt), 8'd3);

      // Random traffic against the model.
      for (int c = 0; c < 3000; c++) begin
         flip = 8'd0;
         for (int b = 0; b < 8; b++)
            if ($urandom_range(7) == 0) flip[b] = 1'b1;
         bus.line_i = bus.line_i ^ flip;
         if ($urandom_range(15) == 0) bus.mask_i = 8'($urandom);
         bus.out_ready_i = ($urandom_range(3) != 0);
         bus.ovf_clr_i   = ($urandom_range(15) == 0);
         if (!rst_n) rst_n = 1'b1;
         else if ($urandom_range(499) == 0) rst_n = 1'b0;
         tick();
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end
endmodule
